// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver: 2-flop synchronizer, tick prescaler, 3-sample majority vote per bit.
// Emits one rxDone per good frame plus single-cycle framing, parity and overrun flags.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | line idle, waiting for a falling edge on rxS
// START  | validating the start bit with a mid-bit majority vote
// DATA   | shifting in DATA_BITS payload bits, LSB first
// PARITY | sampling the parity bit and latching the mismatch flag
// STOP   | sampling the stop bit; good stop releases the byte
// BREAK  | stop bit was low; wait for the line to return high
module uart_rx_oversample #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int CLK_DIV    = 326,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 full,
    output logic [DATA_BITS-1:0] toMem,
    output logic                 rxDone,
    output logic                 frameErr,
    output logic                 parityErr,
    output logic                 overrun,
    output logic                 busy
);

    localparam int TICK_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SAMP_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam int HALF   = OVERSAMPLE / 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } stateT;

    stateT state;
    stateT nextState;

    logic                 rxMeta;
    logic                 rxS;
    logic                 rxPrev;
    logic                 fallEdge;
    logic [TICK_W-1:0]    tickCnt;
    logic                 tick;
    logic [SAMP_W-1:0]    sampleCnt;
    logic [1:0]           voteReg;
    logic                 voteBit;
    logic                 decide;
    logic [BIT_W-1:0]     bitCnt;
    logic [DATA_BITS-1:0] shiftReg;
    logic                 perrReg;
    logic                 doneStage;
    logic                 perrStage;
    logic                 ferrStage;

    logic                 enterStart;
    logic                 shiftEn;
    logic                 parityTake;
    logic                 stopGood;
    logic                 stopBad;

    assign fallEdge = rxPrev & ~rxS;
    assign tick     = (tickCnt == TICK_W'(CLK_DIV - 1));
    assign decide   = tick && (sampleCnt == SAMP_W'(HALF + 1));
    assign voteBit  = (voteReg[1] & voteReg[0]) | (voteReg[1] & rxS) | (voteReg[0] & rxS);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (fallEdge) nextState = START;
            START:   if (decide) nextState = voteBit ? IDLE : DATA;
            DATA:    if (decide && (bitCnt == BIT_W'(DATA_BITS - 1)))
                         nextState = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:  if (decide) nextState = STOP;
            STOP:    if (decide) begin
                         if (!voteBit)     nextState = BREAK;
                         else if (fallEdge) nextState = START;
                         else              nextState = IDLE;
                     end
            BREAK:   if (rxS) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // A start edge landing on the stop-bit decision cycle goes straight to START.
    always_comb begin
        busy       = (state != IDLE);
        enterStart = ((state == IDLE) && fallEdge) ||
                     ((state == STOP) && decide && voteBit && fallEdge);
        shiftEn    = (state == DATA) && decide;
        parityTake = (state == PARITY) && decide;
        stopGood   = (state == STOP) && decide && voteBit;
        stopBad    = (state == STOP) && decide && !voteBit;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxMeta    <= 1'b1;
            rxS       <= 1'b1;
            rxPrev    <= 1'b1;
            tickCnt   <= '0;
            sampleCnt <= '0;
            voteReg   <= 2'b11;
            bitCnt    <= '0;
            shiftReg  <= '0;
            perrReg   <= 1'b0;
        end else begin
            rxMeta <= rx;
            rxS    <= rxMeta;
            rxPrev <= rxS;

            if (enterStart || tick) tickCnt <= '0;
            else                    tickCnt <= tickCnt + 1'b1;

            if (enterStart) begin
                sampleCnt <= '0;
            end else if (tick) begin
                if (sampleCnt == SAMP_W'(OVERSAMPLE - 1)) sampleCnt <= '0;
                else                                      sampleCnt <= sampleCnt + 1'b1;
            end

            if (tick && (sampleCnt == SAMP_W'(HALF - 1))) voteReg[1] <= rxS;
            if (tick && (sampleCnt == SAMP_W'(HALF)))     voteReg[0] <= rxS;

            if ((state == START) && decide) begin
                bitCnt  <= '0;
                perrReg <= 1'b0;
            end else if (shiftEn) begin
                bitCnt <= bitCnt + 1'b1;
            end

            if (shiftEn) shiftReg <= {voteBit, shiftReg[DATA_BITS-1:1]};
            if (parityTake) perrReg <= (^shiftReg) ^ voteBit ^ (PARITY_ODD != 0);
        end
    end

    // One staging flop so the status pulses do not depend on state that the next frame may reuse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            doneStage <= 1'b0;
            perrStage <= 1'b0;
            ferrStage <= 1'b0;
            toMem     <= '0;
            rxDone    <= 1'b0;
            frameErr  <= 1'b0;
            parityErr <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            doneStage <= stopGood;
            perrStage <= stopGood & perrReg;
            ferrStage <= stopBad;
            if (doneStage) toMem <= shiftReg;
            rxDone    <= doneStage;
            parityErr <= perrStage;
            overrun   <= doneStage & full;
            frameErr  <= ferrStage;
        end
    end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample: 8N1 and 8E1 instances at CLK_DIV=4, OVERSAMPLE=16.
module tb_uart_rx_oversample;

    localparam int BIT_CLKS = 64;

    logic       clk;
    logic       reset;
    logic       txLine;
    logic       selP;
    logic       rx;
    logic       rxP;
    logic       full;
    logic       fullP;
    logic [7:0] toMem;
    logic       rxDone, frameErr, parityErr, overrun, busy;
    logic [7:0] toMemP;
    logic       rxDoneP, frameErrP, parityErrP, overrunP, busyP;

    int cmpCnt = 0;
    int errCnt = 0;

    int doneCnt = 0, ferrCnt = 0, perrCnt = 0, ovrCnt = 0, ovrWithDone = 0, longCnt = 0;
    int donePCnt = 0, perrPCnt = 0, perrWithDoneP = 0;
    logic [7:0] lastByte = 8'h00, prevByte = 8'h00;
    logic doneQ = 1'b0, ferrQ = 1'b0, perrQ = 1'b0, ovrQ = 1'b0;

    assign rx  = selP ? 1'b1 : txLine;
    assign rxP = selP ? txLine : 1'b1;

    uart_rx_oversample #(
        .DATA_BITS(8), .OVERSAMPLE(16), .CLK_DIV(4), .PARITY_EN(0), .PARITY_ODD(0)
    ) dut (
        .clk(clk), .reset(reset), .rx(rx), .full(full), .toMem(toMem), .rxDone(rxDone),
        .frameErr(frameErr), .parityErr(parityErr), .overrun(overrun), .busy(busy)
    );

    uart_rx_oversample #(
        .DATA_BITS(8), .OVERSAMPLE(16), .CLK_DIV(4), .PARITY_EN(1), .PARITY_ODD(0)
    ) dutP (
        .clk(clk), .reset(reset), .rx(rxP), .full(fullP), .toMem(toMemP), .rxDone(rxDoneP),
        .frameErr(frameErrP), .parityErr(parityErrP), .overrun(overrunP), .busy(busyP)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rxDone) begin
            doneCnt++;
            prevByte = lastByte;
            lastByte = toMem;
            if (overrun) ovrWithDone++;
        end
        if (frameErr) ferrCnt++;
        if (parityErr) perrCnt++;
        if (overrun) ovrCnt++;
        if ((rxDone && doneQ) || (frameErr && ferrQ) || (parityErr && perrQ) || (overrun && ovrQ))
            longCnt++;
        doneQ = rxDone;
        ferrQ = frameErr;
        perrQ = parityErr;
        ovrQ  = overrun;
        if (rxDoneP) begin
            donePCnt++;
            if (parityErrP) perrWithDoneP++;
        end
        if (parityErrP) perrPCnt++;
    end

    task automatic holdLine(input logic v);
        txLine = v;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic sendFrame(input logic [7:0] data, input bit withPar, input logic parBit,
                             input logic stopBit);
        holdLine(1'b0);
        for (int i = 0; i < 8; i++) holdLine(data[i]);
        if (withPar) holdLine(parBit);
        holdLine(stopBit);
    endtask

    task automatic test_reset;
        int d0;
        repeat (3) @(negedge clk);
        cmpCnt++; if (toMem !== 8'h00) begin errCnt++; $display("FAIL reset_toMem got %h want 00", toMem); end
        cmpCnt++; if (rxDone !== 1'b0) begin errCnt++; $display("FAIL reset_rxDone got %b want 0", rxDone); end
        cmpCnt++; if (frameErr !== 1'b0) begin errCnt++; $display("FAIL reset_frameErr got %b want 0", frameErr); end
        cmpCnt++; if (parityErr !== 1'b0) begin errCnt++; $display("FAIL reset_parityErr got %b want 0", parityErr); end
        cmpCnt++; if (overrun !== 1'b0) begin errCnt++; $display("FAIL reset_overrun got %b want 0", overrun); end
        cmpCnt++; if (busy !== 1'b0) begin errCnt++; $display("FAIL reset_busy got %b want 0", busy); end
        cmpCnt++; if (busyP !== 1'b0) begin errCnt++; $display("FAIL reset_busyP got %b want 0", busyP); end
        reset = 1'b1;
        repeat (10) @(negedge clk);
        d0 = doneCnt;
        holdLine(1'b0);
        txLine = 1'b1;
        repeat (30) @(negedge clk);
        cmpCnt++; if (busy !== 1'b1) begin errCnt++; $display("FAIL midframe_busy got %b want 1", busy); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        cmpCnt++; if (busy !== 1'b0) begin errCnt++; $display("FAIL midreset_busy got %b want 0", busy); end
        cmpCnt++; if (toMem !== 8'h00) begin errCnt++; $display("FAIL midreset_toMem got %h want 00", toMem); end
        reset = 1'b1;
        repeat (20 * BIT_CLKS) @(negedge clk);
        cmpCnt++; if (doneCnt !== d0) begin errCnt++; $display("FAIL midreset_done got %0d want %0d", doneCnt - d0, 0); end
        cmpCnt++; if (busy !== 1'b0) begin errCnt++; $display("FAIL postreset_busy got %b want 0", busy); end
    endtask

    task automatic test_byte_a5;
        int d0, f0, p0, o0;
        d0 = doneCnt; f0 = ferrCnt; p0 = perrCnt; o0 = ovrCnt;
        sendFrame(8'hA5, 1'b0, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        cmpCnt++; if (doneCnt - d0 !== 1) begin errCnt++; $display("FAIL a5_doneCount got %0d want 1", doneCnt - d0); end
        cmpCnt++; if (lastByte !== 8'hA5) begin errCnt++; $display("FAIL a5_byte got %h want a5", lastByte); end
        cmpCnt++; if (toMem !== 8'hA5) begin errCnt++; $display("FAIL a5_toMemHeld got %h want a5", toMem); end
        cmpCnt++; if (ferrCnt - f0 !== 0) begin errCnt++; $display("FAIL a5_frameErr got %0d want 0", ferrCnt - f0); end
        cmpCnt++; if (perrCnt - p0 !== 0) begin errCnt++; $display("FAIL a5_parityErr got %0d want 0", perrCnt - p0); end
        cmpCnt++; if (ovrCnt - o0 !== 0) begin errCnt++; $display("FAIL a5_overrun got %0d want 0", ovrCnt - o0); end
        cmpCnt++; if (busy !== 1'b0) begin errCnt++; $display("FAIL a5_busyAfter got %b want 0", busy); end
    endtask

    task automatic test_glitch;
        int d0, f0;
        d0 = doneCnt; f0 = ferrCnt;
        txLine = 1'b0;
        repeat (12) @(negedge clk);
        txLine = 1'b1;
        repeat (8) @(negedge clk);
        cmpCnt++; if (busy !== 1'b1) begin errCnt++; $display("FAIL glitch_busyStart got %b want 1", busy); end
        repeat (40) @(negedge clk);
        cmpCnt++; if (busy !== 1'b0) begin errCnt++; $display("FAIL glitch_busyClear got %b want 0", busy); end
        repeat (2 * BIT_CLKS) @(negedge clk);
        cmpCnt++; if (doneCnt - d0 !== 0) begin errCnt++; $display("FAIL glitch_done got %0d want 0", doneCnt - d0); end
        cmpCnt++; if (ferrCnt - f0 !== 0) begin errCnt++; $display("FAIL glitch_frameErr got %0d want 0", ferrCnt - f0); end
    endtask

    task automatic test_frame_err;
        int d0, f0;
        d0 = doneCnt; f0 = ferrCnt;
        sendFrame(8'h5A, 1'b0, 1'b0, 1'b0);
        repeat (15 * BIT_CLKS) @(negedge clk);
        cmpCnt++; if (busy !== 1'b1) begin errCnt++; $display("FAIL break_busy got %b want 1", busy); end
        repeat (15 * BIT_CLKS) @(negedge clk);
        txLine = 1'b1;
        repeat (100) @(negedge clk);
        cmpCnt++; if (ferrCnt - f0 !== 1) begin errCnt++; $display("FAIL break_frameErrCount got %0d want 1", ferrCnt - f0); end
        cmpCnt++; if (doneCnt - d0 !== 0) begin errCnt++; $display("FAIL break_done got %0d want 0", doneCnt - d0); end
        cmpCnt++; if (toMem !== 8'hA5) begin errCnt++; $display("FAIL break_toMemKept got %h want a5", toMem); end
        cmpCnt++; if (busy !== 1'b0) begin errCnt++; $display("FAIL break_busyAfter got %b want 0", busy); end
    endtask

    task automatic test_parity;
        int d0, p0, c0;
        selP = 1'b1;
        repeat (10) @(negedge clk);
        d0 = donePCnt; p0 = perrPCnt; c0 = perrWithDoneP;
        sendFrame(8'h07, 1'b1, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        cmpCnt++; if (donePCnt - d0 !== 1) begin errCnt++; $display("FAIL par_bad_done got %0d want 1", donePCnt - d0); end
        cmpCnt++; if (perrWithDoneP - c0 !== 1) begin errCnt++; $display("FAIL par_bad_perrWithDone got %0d want 1", perrWithDoneP - c0); end
        cmpCnt++; if (toMemP !== 8'h07) begin errCnt++; $display("FAIL par_bad_byte got %h want 07", toMemP); end
        d0 = donePCnt; p0 = perrPCnt;
        sendFrame(8'h07, 1'b1, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        cmpCnt++; if (donePCnt - d0 !== 1) begin errCnt++; $display("FAIL par_good_done got %0d want 1", donePCnt - d0); end
        cmpCnt++; if (perrPCnt - p0 !== 0) begin errCnt++; $display("FAIL par_good_parityErr got %0d want 0", perrPCnt - p0); end
        selP = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_overrun;
        int d0, o0, w0;
        d0 = doneCnt; o0 = ovrCnt; w0 = ovrWithDone;
        full = 1'b1;
        sendFrame(8'h3C, 1'b0, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        full = 1'b0;
        cmpCnt++; if (doneCnt - d0 !== 1) begin errCnt++; $display("FAIL ovr_done got %0d want 1", doneCnt - d0); end
        cmpCnt++; if (ovrWithDone - w0 !== 1) begin errCnt++; $display("FAIL ovr_withDone got %0d want 1", ovrWithDone - w0); end
        cmpCnt++; if (ovrCnt - o0 !== 1) begin errCnt++; $display("FAIL ovr_count got %0d want 1", ovrCnt - o0); end
        cmpCnt++; if (toMem !== 8'h3C) begin errCnt++; $display("FAIL ovr_byte got %h want 3c", toMem); end
    endtask

    task automatic test_back_to_back;
        int d0, f0, o0;
        d0 = doneCnt; f0 = ferrCnt; o0 = ovrCnt;
        sendFrame(8'h81, 1'b0, 1'b0, 1'b1);
        sendFrame(8'h7E, 1'b0, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        cmpCnt++; if (doneCnt - d0 !== 2) begin errCnt++; $display("FAIL b2b_done got %0d want 2", doneCnt - d0); end
        cmpCnt++; if (prevByte !== 8'h81) begin errCnt++; $display("FAIL b2b_first got %h want 81", prevByte); end
        cmpCnt++; if (lastByte !== 8'h7E) begin errCnt++; $display("FAIL b2b_second got %h want 7e", lastByte); end
        cmpCnt++; if (ferrCnt - f0 !== 0) begin errCnt++; $display("FAIL b2b_frameErr got %0d want 0", ferrCnt - f0); end
        cmpCnt++; if (ovrCnt - o0 !== 0) begin errCnt++; $display("FAIL b2b_overrun got %0d want 0", ovrCnt - o0); end
    endtask

    task automatic test_pulse_width;
        cmpCnt++; if (longCnt !== 0) begin errCnt++; $display("FAIL pulse_width got %0d long pulses want 0", longCnt); end
    endtask

    initial begin
        reset  = 1'b0;
        txLine = 1'b1;
        selP   = 1'b0;
        full   = 1'b0;
        fullP  = 1'b0;
        test_reset();
        test_byte_a5();
        test_glitch();
        test_frame_err();
        test_parity();
        test_overrun();
        test_back_to_back();
        test_pulse_width();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
        $finish;
    end

endmodule
